// File: rtl/verilog_multiplier_integrated_pkg.sv
// rtl/verilog_multiplier_integrated_pkg.sv - shared widths and signed operand/product types
package verilog_multiplier_integrated_pkg;

  localparam int DEFAULT_WIDTH = 32;
  localparam int PROD_W        = 2 * DEFAULT_WIDTH;

  typedef logic signed [DEFAULT_WIDTH-1:0] operand_t;
  typedef logic signed [PROD_W-1:0]        product_t;

endpackage

// File: rtl/verilog_multiplier_integrated_if.sv
// rtl/verilog_multiplier_integrated_if.sv - operand/enable/product bundle between sequencer and multiplier
interface verilog_multiplier_integrated_if
  import verilog_multiplier_integrated_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic signed [WIDTH-1:0]   a;
  logic signed [WIDTH-1:0]   b;
  logic                      enableA;
  logic                      enableB;
  logic                      enableOut;
  logic signed [2*WIDTH-1:0] product;

  modport master (
    output a, b, enableA, enableB, enableOut,
    input  product
  );

  modport slave (
    input  a, b, enableA, enableB, enableOut,
    output product
  );

endinterface

// File: rtl/verilog_multiplier_integrated_signed_booth_mul.sv
// rtl/verilog_multiplier_integrated_signed_booth_mul.sv - combinational signed radix-4 Booth multiplier
// Partial products are reduced by a binary adder tree stored heap-style (root at index 0).
module verilog_multiplier_integrated_signed_booth_mul
  import verilog_multiplier_integrated_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic signed [WIDTH-1:0]   a,
  input  logic signed [WIDTH-1:0]   b,
  output logic signed [2*WIDTH-1:0] p
);

  localparam int PW  = 2 * WIDTH;
  // Recoded multiplier is padded to an even width with at least one extra sign bit.
  localparam int BW  = WIDTH + 2 - (WIDTH % 2);
  localparam int NPP = BW / 2;
  localparam int LVL = (NPP > 1) ? $clog2(NPP) : 0;
  localparam int NP2 = 1 << LVL;

  logic [BW:0]          bext;
  logic signed [PW-1:0] a_ext;

  assign bext  = {{(BW-WIDTH){b[WIDTH-1]}}, b, 1'b0};
  assign a_ext = {{WIDTH{a[WIDTH-1]}}, a};

  always_comb begin : reduce
    logic signed [PW-1:0] tree [2*NP2-1];
    logic signed [PW-1:0] mag;
    logic [2:0]           sel;
    mag = '0;
    sel = '0;
    for (int i = 0; i < 2*NP2-1; i++) tree[i] = '0;
    for (int g = 0; g < NPP; g++) begin
      sel = bext[2*g +: 3];
      case (sel)
        3'b001, 3'b010: mag = a_ext;
        3'b011:         mag = a_ext <<< 1;
        3'b100:         mag = -(a_ext <<< 1);
        3'b101, 3'b110: mag = -a_ext;
        default:        mag = '0;
      endcase
      tree[NP2-1+g] = mag << (2*g);
    end
    for (int n = NP2-2; n >= 0; n--) tree[n] = tree[2*n+1] + tree[2*n+2];
    p = tree[0];
  end

endmodule

// File: rtl/verilog_multiplier_integrated.sv
// rtl/verilog_multiplier_integrated.sv - registered signed multiplier with independently cleared/enabled registers
// Optional MULT_PIPE_EN adds a free-running pipeline stage before the product register.
module verilog_multiplier_integrated
  import verilog_multiplier_integrated_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input logic                            clk,
  input logic                            resetA,
  input logic                            resetB,
  input logic                            resetOut,
  verilog_multiplier_integrated_if.slave bus
);

  logic signed [WIDTH-1:0]   reg_a;
  logic signed [WIDTH-1:0]   reg_b;
  logic signed [2*WIDTH-1:0] mul_res;
  logic signed [2*WIDTH-1:0] capture_d;
  logic signed [2*WIDTH-1:0] prod_q;

  always_ff @(posedge clk) begin
    if (resetA)           reg_a <= '0;
    else if (bus.enableA) reg_a <= bus.a;
  end

  always_ff @(posedge clk) begin
    if (resetB)           reg_b <= '0;
    else if (bus.enableB) reg_b <= bus.b;
  end

  verilog_multiplier_integrated_signed_booth_mul #(
    .WIDTH (WIDTH)
  ) u_mul (
    .a (reg_a),
    .b (reg_b),
    .p (mul_res)
  );

`ifdef MULT_PIPE_EN
  logic signed [2*WIDTH-1:0] pipe_q;

  always_ff @(posedge clk) begin
    if (resetOut) pipe_q <= '0;
    else          pipe_q <= mul_res;
  end

  assign capture_d = pipe_q;
`else
  assign capture_d = mul_res;
`endif

  always_ff @(posedge clk) begin
    if (resetOut)           prod_q <= '0;
    else if (bus.enableOut) prod_q <= capture_d;
  end

  assign bus.product = prod_q;

endmodule

// File: tb/tb_verilog_multiplier_integrated.sv
// tb/tb_verilog_multiplier_integrated.sv - directed self-checking bench for verilog_multiplier_integrated
module tb_verilog_multiplier_integrated;
  import verilog_multiplier_integrated_pkg::*;

  logic clk = 1'b0;
  logic resetA, resetB, resetOut;
  int   checks = 0;
  int   errors = 0;

  verilog_multiplier_integrated_if bus ();

  verilog_multiplier_integrated dut (
    .clk      (clk),
    .resetA   (resetA),
    .resetB   (resetB),
    .resetOut (resetOut),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Load both operands, then hold enableOut for two edges (valid with or without the pipe stage).
  task automatic run_mul(input operand_t va, input operand_t vb, output product_t res);
    bus.a = va; bus.b = vb;
    bus.enableA = 1'b1; bus.enableB = 1'b1; bus.enableOut = 1'b0;
    step();
    bus.enableA = 1'b0; bus.enableB = 1'b0; bus.enableOut = 1'b1;
    step();
    step();
    bus.enableOut = 1'b0;
    res = bus.product;
  endtask

  task automatic test_reset();
    product_t r;
    resetA = 1'b1; resetB = 1'b1; resetOut = 1'b1;
    step();
    resetA = 1'b0; resetB = 1'b0; resetOut = 1'b0;
    checks++;
    if (bus.product !== 64'h0) begin
      errors++; $display("FAIL reset_product: got %h expected %h", bus.product, 64'h0);
    end
    bus.enableOut = 1'b1;
    step(); step();
    bus.enableOut = 1'b0;
    r = bus.product;
    checks++;
    if (r !== 64'h0) begin
      errors++; $display("FAIL reset_regs_capture: got %h expected %h", r, 64'h0);
    end
  endtask

  task automatic test_positive();
    operand_t va [3] = '{32'h00087234, 32'h50647236, 32'hB887CAAF};
    operand_t vb [3] = '{32'h00000348, 32'h50612336, 32'h887CAAF3};
    product_t ex [3] = '{64'h000000001BB6BAA0, 64'h193DE4CED7437964, 64'h215D8B0A7A419A1D};
    product_t r;
    for (int i = 0; i < 3; i++) begin
      run_mul(va[i], vb[i], r);
      checks++;
      if (r !== ex[i]) begin
        errors++; $display("FAIL same_sign[%0d]: got %h expected %h", i, r, ex[i]);
      end
    end
  endtask

  task automatic test_mixed_sign();
    operand_t va [3] = '{32'h00087234, 32'hFFFFFEFD, 32'h50647236};
    operand_t vb [3] = '{32'hFFFFFEFD, 32'h00087234, 32'hB887CAAF};
    product_t ex [3] = '{64'hFFFFFFFFF7747564, 64'hFFFFFFFFF7747564, 64'hE98E647F4142AEEA};
    product_t r;
    for (int i = 0; i < 3; i++) begin
      run_mul(va[i], vb[i], r);
      checks++;
      if (r !== ex[i]) begin
        errors++; $display("FAIL mixed_sign[%0d]: got %h expected %h", i, r, ex[i]);
      end
    end
  endtask

  task automatic test_identity_zero();
    operand_t va [5] = '{32'h00000001, 32'hB887CAAF, 32'h00000000, 32'h887CAAF3, 32'hFFFFFEFD};
    operand_t vb [5] = '{32'h50647236, 32'h00000001, 32'hB887CAAF, 32'h00000000, 32'hFFFFFEFD};
    product_t ex [5] = '{64'h0000000050647236, 64'hFFFFFFFFB887CAAF, 64'h0, 64'h0, 64'h0000000000010609};
    product_t r;
    for (int i = 0; i < 5; i++) begin
      run_mul(va[i], vb[i], r);
      checks++;
      if (r !== ex[i]) begin
        errors++; $display("FAIL identity_zero[%0d]: got %h expected %h", i, r, ex[i]);
      end
    end
  endtask

  task automatic test_most_negative();
    product_t r;
    run_mul(32'h80000000, 32'h80000000, r);
    checks++;
    if (r !== 64'h4000000000000000) begin
      errors++; $display("FAIL most_negative: got %h expected %h", r, 64'h4000000000000000);
    end
    run_mul(32'h80000000, 32'h00000001, r);
    checks++;
    if (r !== 64'hFFFFFFFF80000000) begin
      errors++; $display("FAIL most_negative_x1: got %h expected %h", r, 64'hFFFFFFFF80000000);
    end
  endtask

  task automatic test_control();
    product_t r;
    run_mul(32'h00087234, 32'h00000348, r);
    // Operands change but product must hold while enableOut stays low.
    bus.a = 32'h50647236; bus.b = 32'h50612336;
    bus.enableA = 1'b1; bus.enableB = 1'b1;
    step(); step();
    bus.enableA = 1'b0; bus.enableB = 1'b0;
    step();
    checks++;
    if (bus.product !== 64'h000000001BB6BAA0) begin
      errors++; $display("FAIL hold: got %h expected %h", bus.product, 64'h000000001BB6BAA0);
    end
    bus.enableOut = 1'b1; resetOut = 1'b1;
    step();
    resetOut = 1'b0; bus.enableOut = 1'b0;
    checks++;
    if (bus.product !== 64'h0) begin
      errors++; $display("FAIL resetout_priority: got %h expected %h", bus.product, 64'h0);
    end
    bus.enableOut = 1'b1;
    step(); step();
    bus.enableOut = 1'b0;
    checks++;
    if (bus.product !== 64'h193DE4CED7437964) begin
      errors++; $display("FAIL track_after_reset: got %h expected %h", bus.product, 64'h193DE4CED7437964);
    end
    resetA = 1'b1; bus.enableA = 1'b1; bus.a = 32'h00000005;
    step();
    resetA = 1'b0; bus.enableA = 1'b0; bus.enableOut = 1'b1;
    step(); step();
    bus.enableOut = 1'b0;
    checks++;
    if (bus.product !== 64'h0) begin
      errors++; $display("FAIL reseta_capture: got %h expected %h", bus.product, 64'h0);
    end
  endtask

  task automatic test_back_to_back();
    product_t r;
    run_mul(32'h80000000, 32'h80000000, r);
    bus.a = 32'h00087234; bus.b = 32'h00000348;
    bus.enableA = 1'b1; bus.enableB = 1'b1;
    step();
    bus.a = 32'h00000001; bus.b = 32'h50647236; bus.enableOut = 1'b1;
    step();
    checks++;
    if (bus.product !== 64'h000000001BB6BAA0) begin
      errors++; $display("FAIL b2b_old_contents: got %h expected %h", bus.product, 64'h000000001BB6BAA0);
    end
    bus.enableA = 1'b0; bus.enableB = 1'b0;
    step();
    bus.enableOut = 1'b0;
    checks++;
    if (bus.product !== 64'h0000000050647236) begin
      errors++; $display("FAIL b2b_new_contents: got %h expected %h", bus.product, 64'h0000000050647236);
    end
  endtask

  initial begin
    resetA = 1'b0; resetB = 1'b0; resetOut = 1'b0;
    bus.a = '0; bus.b = '0;
    bus.enableA = 1'b0; bus.enableB = 1'b0; bus.enableOut = 1'b0;
    step();
    test_reset();
    test_positive();
    test_mixed_sign();
    test_identity_zero();
    test_most_negative();
    test_control();
`ifndef MULT_PIPE_EN
    test_back_to_back();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
